bpi_flash_sequencer: RTL and testbench
======================================

# bpi_flash_sequencer

Parametrised BPI parallel-flash bus sequencer: accepts single-word write, single-word read and multi-word burst read commands from the PROM command layer, and generates address-latch, chip-enable, output-enable and write-enable strobes with programmable setup, pulse and hold widths. It sits between the PROM command decoder and the FPGA pad ring; pad buffers are instantiated outside this block. It also muxes the shared DQ lines with non-BPI dual-purpose data.

## Interface
- ADDR_W, 23: flash address width
- DATA_W, 16: flash data width
- T_SETUP, 1: cycles flatch_b held low per word (≥1)
- T_PULSE, 3: cycles fwe_b or foe_b held low per word (≥1)
- T_HOLD, 1: recovery cycles after the last word (≥1)
- BURST_W, 4: width of BURST_LEN; maximum burst is 2^BURST_W words

- CLK  in  1  system clock; one clock domain
- RST  in  1  synchronous, active-high reset
- ADDR  in  ADDR_W  start address
- CMD_DATA_OUT  in  DATA_W  write data or command word
- OP  in  2  00 standby, 01 write, 10 read, 11 standby
- BURST_LEN  in  BURST_W  extra words for a read (0 = one word); ignored for writes
- EXECUTE  in  1  start strobe; sampled only while BUSY=0
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle pulse on the last cycle of an operation
- DATA_IN  out  DATA_W  registered read word
- LOAD_DATA  out  1  one-cycle qualifier for DATA_IN
- BPI_ACTIVE  in  1  DQ lines are reserved for BPI
- DUAL_DATA  in  DATA_W  data driven on DQ when not in BPI use
- flash_ad  out  ADDR_W  address to pads
- flash_dq_i  in  DATA_W  DQ from pads
- flash_dq_o  out  DATA_W  DQ to pads
- flash_dq_t  out  1  DQ tristate (1 = release)
- fcs_b, foe_b, fwe_b, flatch_b  out  1 each  active-low flash strobes

## Operation
- Reset values:
  - BUSY=0, DONE=0, LOAD_DATA=0, DATA_IN=0
  - flash_ad=0
  - all strobes=1
  - flash_dq_t=0
  - state IDLE
- Command acceptance: EXECUTE=1 with BUSY=0 and OP∈{01,10} registers ADDR, CMD_DATA_OUT, OP and BURST_LEN.
  - EXECUTE with OP∈{00,11} is ignored; BUSY stays 0.
  - EXECUTE while BUSY=1 is ignored; there is no queueing.
- States:
  - IDLE → LATCH
  - LATCH: T_SETUP cycles; fcs_b=0, flatch_b=0. Then WR_PULSE if write, RD_PULSE if read.
  - WR_PULSE: T_PULSE cycles; fcs_b=0, fwe_b=0. Then RECOVER.
  - RD_PULSE: T_PULSE cycles; fcs_b=0, foe_b=0. flash_dq_i is registered into DATA_IN at the clock edge ending the last cycle. Then RD_NEXT if words remain, else RECOVER.
  - RD_NEXT: 1 cycle; fcs_b=0, foe_b=1. flash_ad increments by 1, modulo 2^ADDR_W (wraps from all-ones to 0). Remaining count decrements. Then LATCH.
  - RECOVER: T_HOLD cycles, all strobes 1. DONE=1 on the last cycle. Then IDLE.
- LOAD_DATA=1 for exactly the one cycle after each last RD_PULSE cycle, i.e. the first cycle of RD_NEXT or RECOVER.
- Burst length: a read produces BURST_LEN+1 LOAD_DATA pulses.
- DQ drive:
  - flash_dq_t=1 during LATCH/RD_PULSE/RD_NEXT of a read, and during the first RECOVER cycle of a read.
  - flash_dq_t=0 otherwise.
- DQ data: flash_dq_o = held CMD_DATA_OUT while BUSY=1 or BPI_ACTIVE=1; otherwise flash_dq_o = DUAL_DATA (combinational pass-through).
- RST mid-operation: the next edge forces reset values. Strobes must never glitch low. No DONE or LOAD_DATA is issued for the aborted operation.
- All strobes are driven from registers; there are no combinational paths to strobe outputs.

## Timing
- EXECUTE is accepted at edge 0.
- BUSY is high from cycle 1 through the last RECOVER cycle. DONE coincides with that last cycle.
- flash_ad is valid from cycle 1. It is stable whenever flatch_b=0 or fcs_b=0, except at RD_NEXT entry.
- Write latency, BUSY cycles: T_SETUP+T_PULSE+T_HOLD. Defaults give 5 (cycles 1–5).
- Read latency, BUSY cycles: (BURST_LEN+1)·(T_SETUP+T_PULSE) + BURST_LEN + T_HOLD.
- EXECUTE is re-accepted in the first cycle BUSY=0, back-to-back with no gap.

## Test plan
- Reset check: assert RST for 3 cycles → all strobes 1, BUSY=0, DONE=0, flash_dq_t=0.
- Write, defaults, ADDR=0x12345, data 0x00FF:
  - flatch_b low cycle 1; fwe_b low cycles 2–4; fcs_b low cycles 1–4.
  - DQ driven 0x00FF cycles 1–5; DONE cycle 5; BUSY=0 at cycle 6.
- Single read, model returns 0xA5C3: foe_b low cycles 2–4; flash_dq_t=1; LOAD_DATA=1 with DATA_IN=0xA5C3 at cycle 5; DONE cycle 5.
- Burst read, BURST_LEN=2, ADDR=0x7FFFFF, model data = low address bits:
  - addresses 0x7FFFFF, 0x000000, 0x000001.
  - 3 LOAD_DATA pulses at cycles 5, 10, 15; DONE cycle 15.
- Busy and illegal command checks:
  - EXECUTE pulsed mid-write → ignored, single DONE.
  - OP=11 with EXECUTE → BUSY stays 0.
- Reset abort and DQ mux:
  - RST in RD_PULSE → strobes 1 next cycle, no LOAD_DATA.
  - BUSY=0, BPI_ACTIVE=0, DUAL_DATA=0x1234 → flash_dq_o=0x1234.

Source files
------------

// File: rtl/bpi_flash_sequencer.sv
// BPI parallel-flash bus sequencer: turns single write, single read and burst
// read commands into registered latch/chip-enable/output-enable/write-enable strobes.
module bpi_flash_sequencer #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 16,
  parameter int T_SETUP = 1,
  parameter int T_PULSE = 3,
  parameter int T_HOLD  = 1,
  parameter int BURST_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] CMD_DATA_OUT,
  input  logic [1:0]        OP,
  input  logic [BURST_W-1:0] BURST_LEN,
  input  logic              EXECUTE,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] DATA_IN,
  output logic              LOAD_DATA,
  input  logic              BPI_ACTIVE,
  input  logic [DATA_W-1:0] DUAL_DATA,
  output logic [ADDR_W-1:0] flash_ad,
  input  logic [DATA_W-1:0] flash_dq_i,
  output logic [DATA_W-1:0] flash_dq_o,
  output logic              flash_dq_t,
  output logic              fcs_b,
  output logic              foe_b,
  output logic              fwe_b,
  output logic              flatch_b
);

  localparam int T_SP  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int T_MAX = (T_SP > T_HOLD) ? T_SP : T_HOLD;
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CNT_W-1:0] SETUP_INIT = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_INIT = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_INIT  = CNT_W'(T_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    WR_PULSE,
    RD_PULSE,
    RD_NEXT,
    RECOVER
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [BURST_W-1:0]  remain, remain_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   data_q, data_n;
  logic [DATA_W-1:0]   din_n;
  logic                is_read, is_read_n;
  logic                first_recover;
  logic                busy_n, done_n, load_n, dq_t_n;
  logic                fcs_n, foe_n, fwe_n, flatch_n;

  // Next-state logic; the strobe values below are computed from the next state
  // so every pad strobe comes straight out of a flop.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    remain_n      = remain;
    addr_n        = flash_ad;
    data_n        = data_q;
    din_n         = DATA_IN;
    is_read_n     = is_read;
    load_n        = 1'b0;
    first_recover = 1'b0;

    case (state)
      IDLE: begin
        if (EXECUTE && (OP == 2'b01 || OP == 2'b10)) begin
          state_n   = LATCH;
          cnt_n     = SETUP_INIT;
          addr_n    = ADDR;
          data_n    = CMD_DATA_OUT;
          is_read_n = (OP == 2'b10);
          remain_n  = BURST_LEN;
        end
      end
      LATCH: begin
        if (cnt == '0) begin
          state_n = is_read ? RD_PULSE : WR_PULSE;
          cnt_n   = PULSE_INIT;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      WR_PULSE: begin
        if (cnt == '0) begin
          state_n = RECOVER;
          cnt_n   = HOLD_INIT;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RD_PULSE: begin
        if (cnt == '0) begin
          load_n = 1'b1;
          din_n  = flash_dq_i;
          if (remain != '0) begin
            // Address advances on RD_NEXT entry, wrapping naturally at the top.
            state_n  = RD_NEXT;
            addr_n   = flash_ad + 1'b1;
            remain_n = remain - 1'b1;
          end else begin
            state_n       = RECOVER;
            cnt_n         = HOLD_INIT;
            first_recover = 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RD_NEXT: begin
        state_n = LATCH;
        cnt_n   = SETUP_INIT;
      end
      RECOVER: begin
        if (cnt == '0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n   = (state_n != IDLE);
    done_n   = (state_n == RECOVER) && (cnt_n == '0);
    fcs_n    = !(state_n == LATCH || state_n == WR_PULSE ||
                 state_n == RD_PULSE || state_n == RD_NEXT);
    flatch_n = !(state_n == LATCH);
    fwe_n    = !(state_n == WR_PULSE);
    foe_n    = !(state_n == RD_PULSE);
    dq_t_n   = is_read_n && (state_n == LATCH || state_n == RD_PULSE ||
                             state_n == RD_NEXT || first_recover);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      remain     <= '0;
      flash_ad   <= '0;
      data_q     <= '0;
      DATA_IN    <= '0;
      is_read    <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      LOAD_DATA  <= 1'b0;
      flash_dq_t <= 1'b0;
      fcs_b      <= 1'b1;
      foe_b      <= 1'b1;
      fwe_b      <= 1'b1;
      flatch_b   <= 1'b1;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      remain     <= remain_n;
      flash_ad   <= addr_n;
      data_q     <= data_n;
      DATA_IN    <= din_n;
      is_read    <= is_read_n;
      BUSY       <= busy_n;
      DONE       <= done_n;
      LOAD_DATA  <= load_n;
      flash_dq_t <= dq_t_n;
      fcs_b      <= fcs_n;
      foe_b      <= foe_n;
      fwe_b      <= fwe_n;
      flatch_b   <= flatch_n;
    end
  end

  // DQ lines carry the held command word whenever BPI owns them.
  assign flash_dq_o = (BUSY || BPI_ACTIVE) ? data_q : DUAL_DATA;

endmodule

// File: tb/tb_bpi_flash_sequencer.sv
// Scoreboard bench for bpi_flash_sequencer: directed timing checks plus
// randomized commands checked against a word-level model of the bus.
module tb_bpi_flash_sequencer;

  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 16;
  localparam int T_SETUP = 1;
  localparam int T_PULSE = 3;
  localparam int T_HOLD  = 1;
  localparam int BURST_W = 4;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic [ADDR_W-1:0]  ADDR = '0;
  logic [DATA_W-1:0]  CMD_DATA_OUT = '0;
  logic [1:0]         OP = 2'b00;
  logic [BURST_W-1:0] BURST_LEN = '0;
  logic               EXECUTE = 1'b0;
  logic               BUSY, DONE, LOAD_DATA;
  logic [DATA_W-1:0]  DATA_IN;
  logic               BPI_ACTIVE = 1'b0;
  logic [DATA_W-1:0]  DUAL_DATA = '0;
  logic [ADDR_W-1:0]  flash_ad;
  logic [DATA_W-1:0]  flash_dq_i;
  logic [DATA_W-1:0]  flash_dq_o;
  logic               flash_dq_t, fcs_b, foe_b, fwe_b, flatch_b;

  int tests_run = 0;
  int tests_failed = 0;

  logic [ADDR_W-1:0] exp_addr[$];
  logic [DATA_W-1:0] exp_word[$];
  logic [DATA_W-1:0] exp_wdata[$];
  int                exp_lat[$];
  logic [DATA_W-1:0] held_data = '0;
  logic [15:0]       mem_key = '0;

  bpi_flash_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_SETUP(T_SETUP),
    .T_PULSE(T_PULSE), .T_HOLD(T_HOLD), .BURST_W(BURST_W)
  ) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .CMD_DATA_OUT(CMD_DATA_OUT), .OP(OP),
    .BURST_LEN(BURST_LEN), .EXECUTE(EXECUTE), .BUSY(BUSY), .DONE(DONE),
    .DATA_IN(DATA_IN), .LOAD_DATA(LOAD_DATA), .BPI_ACTIVE(BPI_ACTIVE),
    .DUAL_DATA(DUAL_DATA), .flash_ad(flash_ad), .flash_dq_i(flash_dq_i),
    .flash_dq_o(flash_dq_o), .flash_dq_t(flash_dq_t), .fcs_b(fcs_b),
    .foe_b(foe_b), .fwe_b(fwe_b), .flatch_b(flatch_b)
  );

  always #5 CLK = ~CLK;

  // Flash model: while output-enabled, returns the address low bits xor a key.
  assign flash_dq_i = foe_b ? 16'hDEAD : (flash_ad[15:0] ^ mem_key);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  // Issues one command once the sequencer is idle and records what it must produce.
  task automatic applyStimulus(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data,
                               input logic [BURST_W-1:0] blen);
    int n;
    logic [ADDR_W-1:0] a;
    n = 0;
    while (BUSY && n < 200) begin
      tick();
      n++;
    end
    if (BUSY) checkOutput("idle_timeout", BUSY, 0);
    OP = op;
    ADDR = addr;
    CMD_DATA_OUT = data;
    BURST_LEN = blen;
    EXECUTE = 1'b1;
    tick();
    EXECUTE = 1'b0;
    if (op == 2'b01) begin
      exp_addr.push_back(addr);
      exp_wdata.push_back(data);
      exp_lat.push_back(T_SETUP + T_PULSE + T_HOLD);
      held_data = data;
      checkOutput("accept_busy", BUSY, 1);
    end else if (op == 2'b10) begin
      for (int i = 0; i <= int'(blen); i++) begin
        a = addr + ADDR_W'(i);
        exp_addr.push_back(a);
        exp_word.push_back(a[15:0] ^ mem_key);
      end
      exp_lat.push_back((int'(blen) + 1) * (T_SETUP + T_PULSE) + int'(blen) + T_HOLD);
      held_data = data;
      checkOutput("accept_busy", BUSY, 1);
    end
  endtask

  // Monitor: pops expectations whenever the bus shows a latch, write, load or done.
  logic prev_flatch = 1'b1;
  logic prev_fwe = 1'b1;
  int   busy_cnt = 0;

  always @(negedge CLK) begin
    if (RST) begin
      busy_cnt = 0;
      prev_flatch = 1'b1;
      prev_fwe = 1'b1;
    end else begin
      if (BUSY) busy_cnt++;
      if (!flatch_b && prev_flatch) begin
        if (exp_addr.size() == 0) checkOutput("unexpected_latch", exp_addr.size(), 1);
        else checkOutput("latch_addr", flash_ad, exp_addr.pop_front());
      end
      if (!fwe_b && prev_fwe) begin
        checkOutput("write_dq_t", flash_dq_t, 0);
        if (exp_wdata.size() == 0) checkOutput("unexpected_write", exp_wdata.size(), 1);
        else checkOutput("write_dq", flash_dq_o, exp_wdata.pop_front());
      end
      if (!foe_b) checkOutput("read_dq_t", flash_dq_t, 1);
      if (LOAD_DATA) begin
        if (exp_word.size() == 0) checkOutput("unexpected_load", exp_word.size(), 1);
        else checkOutput("read_word", DATA_IN, exp_word.pop_front());
      end
      if (DONE) begin
        if (exp_lat.size() == 0) checkOutput("unexpected_done", exp_lat.size(), 1);
        else checkOutput("busy_cycles", busy_cnt, exp_lat.pop_front());
        busy_cnt = 0;
      end
      checkOutput("dq_mux", flash_dq_o, (BUSY || BPI_ACTIVE) ? held_data : DUAL_DATA);
      checkOutput("strobe_consistency",
                  32'((foe_b | fwe_b) && (!fcs_b || (foe_b && fwe_b && flatch_b))), 1);
      prev_flatch = flatch_b;
      prev_fwe = fwe_b;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [1:0]        rop;

    // Reset held for three edges
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_strobes", {fcs_b, foe_b, fwe_b, flatch_b}, 4'hF);
    checkOutput("rst_busy", BUSY, 0);
    checkOutput("rst_done", DONE, 0);
    checkOutput("rst_load", LOAD_DATA, 0);
    checkOutput("rst_dq_t", flash_dq_t, 0);
    checkOutput("rst_ad", flash_ad, 0);
    checkOutput("rst_data_in", DATA_IN, 0);
    tick();
    RST = 1'b0;
    tick();

    // Directed write, cycle by cycle
    BPI_ACTIVE = 1'b0;
    applyStimulus(2'b01, 23'h12345, 16'h00FF, 4'd0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      checkOutput($sformatf("wr_flatch_c%0d", c), flatch_b, (c == 1) ? 0 : 1);
      checkOutput($sformatf("wr_fwe_c%0d", c), fwe_b, (c >= 2 && c <= 4) ? 0 : 1);
      checkOutput($sformatf("wr_fcs_c%0d", c), fcs_b, (c <= 4) ? 0 : 1);
      checkOutput($sformatf("wr_done_c%0d", c), DONE, (c == 5) ? 1 : 0);
      checkOutput($sformatf("wr_busy_c%0d", c), BUSY, (c <= 5) ? 1 : 0);
      if (c <= 5) checkOutput($sformatf("wr_dq_c%0d", c), flash_dq_o, 16'h00FF);
      if (c <= 5) checkOutput($sformatf("wr_ad_c%0d", c), flash_ad, 23'h12345);
    end
    tick();

    // Directed single read
    mem_key = 16'hA5C3;
    applyStimulus(2'b10, 23'h000000, 16'h0000, 4'd0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      checkOutput($sformatf("rd_foe_c%0d", c), foe_b, (c >= 2 && c <= 4) ? 0 : 1);
      checkOutput($sformatf("rd_dq_t_c%0d", c), flash_dq_t, (c <= 5) ? 1 : 0);
      checkOutput($sformatf("rd_load_c%0d", c), LOAD_DATA, (c == 5) ? 1 : 0);
      checkOutput($sformatf("rd_done_c%0d", c), DONE, (c == 5) ? 1 : 0);
      if (c == 5) checkOutput("rd_data_in", DATA_IN, 16'hA5C3);
    end
    tick();

    // Directed burst read across the address wrap
    mem_key = 16'h0000;
    applyStimulus(2'b10, 23'h7FFFFF, 16'h0000, 4'd2);
    for (int c = 1; c <= 16; c++) begin
      @(negedge CLK);
      checkOutput($sformatf("br_load_c%0d", c), LOAD_DATA,
                  (c == 5 || c == 10 || c == 15) ? 1 : 0);
      checkOutput($sformatf("br_done_c%0d", c), DONE, (c == 15) ? 1 : 0);
      if (c == 1)  checkOutput("br_ad_w0", flash_ad, 23'h7FFFFF);
      if (c == 6)  checkOutput("br_ad_w1", flash_ad, 23'h000000);
      if (c == 11) checkOutput("br_ad_w2", flash_ad, 23'h000001);
      if (c == 15) checkOutput("br_last_word", DATA_IN, 16'h0001);
    end
    tick();

    // EXECUTE while busy is ignored
    applyStimulus(2'b01, 23'h000100, 16'hBEEF, 4'd0);
    tick();
    OP = 2'b10;
    ADDR = 23'h000200;
    EXECUTE = 1'b1;
    tick();
    EXECUTE = 1'b0;
    repeat (6) tick();
    checkOutput("busy_ignore_idle", BUSY, 0);
    checkOutput("busy_ignore_drained", exp_lat.size(), 0);

    // Illegal opcodes do not start anything
    applyStimulus(2'b11, 23'h000300, 16'h1111, 4'd0);
    checkOutput("op11_busy", BUSY, 0);
    applyStimulus(2'b00, 23'h000300, 16'h1111, 4'd0);
    checkOutput("op00_busy", BUSY, 0);
    tick();
    checkOutput("illegal_still_idle", BUSY, 0);

    // Dual-purpose data pass-through
    BPI_ACTIVE = 1'b0;
    DUAL_DATA = 16'h1234;
    @(negedge CLK);
    checkOutput("dual_passthrough", flash_dq_o, 16'h1234);
    BPI_ACTIVE = 1'b1;
    @(negedge CLK);
    checkOutput("bpi_active_held", flash_dq_o, held_data);
    tick();

    // Reset during RD_PULSE aborts without LOAD_DATA or DONE
    applyStimulus(2'b10, 23'h000400, 16'h2222, 4'd3);
    tick();
    RST = 1'b1;
    tick();
    exp_addr.delete();
    exp_word.delete();
    exp_wdata.delete();
    exp_lat.delete();
    held_data = '0;
    @(negedge CLK);
    checkOutput("abort_strobes", {fcs_b, foe_b, fwe_b, flatch_b}, 4'hF);
    checkOutput("abort_busy", BUSY, 0);
    checkOutput("abort_load", LOAD_DATA, 0);
    checkOutput("abort_dq_t", flash_dq_t, 0);
    tick();
    RST = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      checkOutput("abort_no_load", LOAD_DATA, 0);
      checkOutput("abort_no_done", DONE, 0);
    end
    tick();

    // Randomized commands, back-to-back or with small gaps
    for (int k = 0; k < 40; k++) begin
      if (!BUSY) mem_key = 16'($urandom);
      BPI_ACTIVE = 1'($urandom_range(0, 1));
      DUAL_DATA = 16'($urandom);
      rop = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      ra = ($urandom_range(0, 1) == 0) ? (23'h7FFFFF - 23'($urandom_range(0, 3)))
                                       : 23'($urandom);
      applyStimulus(rop, ra, 16'($urandom), 4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) tick();
    end

    begin
      int n;
      n = 0;
      while (BUSY && n < 300) begin
        tick();
        n++;
      end
      checkOutput("final_idle", BUSY, 0);
    end
    repeat (3) tick();
    checkOutput("queues_drained",
                exp_addr.size() + exp_word.size() + exp_wdata.size() + exp_lat.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
